// File: rtl/bit_shift_left16_if.sv
// Operand/result bundle for bit_shift_left16.
// The ovf signal exists only when BSL16_OVF_EN is defined.
interface bit_shift_left16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             out_valid;
`ifdef BSL16_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, input out, out_valid, ovf);
  modport slave  (input in_valid, a, b, output out, out_valid, ovf);
`else
  modport master (output in_valid, a, b, input out, out_valid);
  modport slave  (input in_valid, a, b, output out, out_valid);
`endif
endinterface

// File: rtl/bit_shift_left16.sv
// 16-bit logical left shifter: log2 barrel network (1/2/4/8) plus one output register.
// Optional ovf output (a 1 bit was shifted out) is enabled with BSL16_OVF_EN.
module bit_shift_left16 #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bit_shift_left16_if.slave bus
);

  logic [WIDTH-1:0] s1, s2, s3, s4;
  logic [WIDTH-1:0] result;
  logic             too_big;

  // Any set bit above the shift-amount field means a shift of 16 or more.
  assign too_big = |bus.b[WIDTH-1:SHAMT_W];

  assign s1 = bus.b[0] ? {bus.a[WIDTH-2:0], 1'b0} : bus.a;
  assign s2 = bus.b[1] ? {s1[WIDTH-3:0],    2'b0} : s1;
  assign s3 = bus.b[2] ? {s2[WIDTH-5:0],    4'b0} : s2;
  assign s4 = bus.b[3] ? {s3[WIDTH-9:0],    8'b0} : s3;

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    result = s4;
    if (too_big) result = '0;
  end

`ifdef BSL16_OVF_EN
  logic ovf_next;

  // Each active stage loses its top 2^k bits; a huge shift loses all of a.
  always_comb begin
    ovf_next = (bus.b[0] &  bus.a[WIDTH-1])
             | (bus.b[1] & |s1[WIDTH-1:WIDTH-2])
             | (bus.b[2] & |s2[WIDTH-1:WIDTH-4])
             | (bus.b[3] & |s3[WIDTH-1:WIDTH-8]);
    if (too_big) ovf_next = |bus.a;
  end
`endif

  // NOTE: registers use non-blocking assignments; out is reset too so it is
  // never X even when a/b float while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
`ifdef BSL16_OVF_EN
      bus.ovf       <= 1'b0;
`endif
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out <= result;
`ifdef BSL16_OVF_EN
        bus.ovf <= ovf_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bit_shift_left16.sv
// Self-checking bench for bit_shift_left16: directed boundary steps then randomized
// operations against an arithmetic reference model. Honors BSL16_OVF_EN.
module tb_bit_shift_left16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [15:0] exp_out;
  logic        exp_valid;
  logic        exp_ovf;

  bit_shift_left16_if bus ();

  bit_shift_left16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] ref_out(input logic [15:0] aa, input logic [15:0] bb);
    logic [31:0] wide;
    wide = {16'h0, aa} << bb;
    return (bb > 16'd15) ? 16'h0000 : wide[15:0];
  endfunction

  function automatic logic ref_ovf(input logic [15:0] aa, input logic [15:0] bb);
    logic [31:0] wide;
    wide = {16'h0, aa} << bb[4:0];
    if (bb == 16'd0) return 1'b0;
    if (bb > 16'd15) return aa != 16'h0000;
    return wide[31:16] != 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"}, bus.out, exp_out);
    check({tag, ".out_valid"}, {15'h0, bus.out_valid}, {15'h0, exp_valid});
`ifdef BSL16_OVF_EN
    check({tag, ".ovf"}, {15'h0, bus.ovf}, {15'h0, exp_ovf});
`endif
  endtask

  // Drive one cycle of inputs, update the model, and check after the edge.
  task automatic step(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                      input string tag);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = aa;
    bus.b        = bb;
    if (v) begin
      exp_out = ref_out(aa, bb);
      exp_ovf = ref_ovf(aa, bb);
    end
    exp_valid = v;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 16'h0;
    bus.b        = 16'h0;
    exp_out      = 16'h0;
    exp_valid    = 1'b0;
    exp_ovf      = 1'b0;

    #3;
    check_all("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 16'h0000, 16'h0000, "zero_zero");
    step(1'b1, 16'h0001, 16'h0001, "one_by_one");

    // Asynchronous reset mid-stream while out holds 0002.
    #2;
    rst_n = 1'b0;
    exp_out = 16'h0; exp_valid = 1'b0; exp_ovf = 1'b0;
    #1;
    check_all("reset_async");
    bus.in_valid = 1'b1;
    bus.a        = 16'h0005;
    bus.b        = 16'h0001;
    @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    step(1'b0, 16'h0005, 16'h0001, "after_release");

    step(1'b1, 16'h0001, 16'h0002, "b2b_shift2");
    step(1'b1, 16'h0001, 16'h000F, "b2b_shift15");
    step(1'b1, 16'hFFFF, 16'h0010, "b_eq_16");
    step(1'b1, 16'hFFFF, 16'h0104, "b_upper_bits");
    step(1'b1, 16'h1234, 16'h0004, "hold_load");
    step(1'b0, 16'hFFFF, 16'h0004, "hold_idle1");
    step(1'b0, 16'hxxxx, 16'hxxxx, "hold_x_inputs");
    step(1'b1, 16'hA5A5, 16'h000F, "b15_msb");

    for (int i = 0; i <= 17; i++) begin
      ra = 16'($urandom);
      step(1'b1, ra, 16'(i), $sformatf("sweep_b%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      rb = 16'($urandom);
      step(1'b1, 16'h0000, rb, $sformatf("a_zero_%0d", i));
    end

    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
      step(1'($urandom_range(0, 3) != 0), ra, rb, $sformatf("rand_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
